sweep_result_collector: RTL and testbench

- Receiving end of the sweep controller's result stream.
- Captures the modulus and phase result for each frequency point. Each result arrives with a valid strobe and a point index, and the two results for a point can arrive in either order.
- Stores results in two banked RAMs, tracks which points are complete, and signals end of sweep.
- Gives the processing-system bus read-back of the results with fixed latency.

---
 rtl/sweep_result_collector.sv | 131 +++++++++++++
 tb/tb_sweep_result_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sweep_result_collector.sv
// Collects modulus/phase results per sweep point into two banks and flags end of sweep.
// Flags and count update 1 cycle after a strobe, DONE 2 cycles after; reads return 1 cycle after sys_rd, with no backpressure.
module sweep_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk125,
  input  logic                  areset,
  input  logic                  arm,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic                  valid_m,
  input  logic [DATA_WIDTH-1:0] modulo,
  input  logic [ADDR_WIDTH-1:0] address_m,
  input  logic                  valid_p,
  input  logic [DATA_WIDTH-1:0] phase,
  input  logic [ADDR_WIDTH-1:0] address_p,
  input  logic                  sys_rd,
  input  logic [ADDR_WIDTH:0]   sys_addr,
  output logic [DATA_WIDTH-1:0] sys_rdata,
  output logic                  sys_rvalid,
  output logic                  sys_rflag,
  output logic [ADDR_WIDTH:0]   point_count,
  output logic                  collecting,
  output logic                  done,
  output logic                  dup_err,
  output logic                  range_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] num_lat;
  logic [DEPTH-1:0]      flag_m;
  logic [DEPTH-1:0]      flag_p;
  logic [DATA_WIDTH-1:0] ram_m [DEPTH];
  logic [DATA_WIDTH-1:0] ram_p [DEPTH];

  logic                  accept;
  logic                  wr_m, wr_p, rng_m, rng_p, dup_m, dup_p;
  logic                  comp_m, comp_p;
  logic [1:0]            inc;
  logic [ADDR_WIDTH+1:0] count_sum;
  logic [ADDR_WIDTH:0]   count_next;

  always_comb begin
    accept = (state == S_COLLECT) && !clear;
    wr_m   = accept && valid_m && (address_m < num_lat);
    wr_p   = accept && valid_p && (address_p < num_lat);
    rng_m  = accept && valid_m && !(address_m < num_lat);
    rng_p  = accept && valid_p && !(address_p < num_lat);
    dup_m  = wr_m && flag_m[address_m];
    dup_p  = wr_p && flag_p[address_p];
    // When both halves of one point land together, only the modulus side counts it.
    comp_m = wr_m && !flag_m[address_m] &&
             (flag_p[address_m] || (wr_p && (address_p == address_m) && !flag_p[address_p]));
    comp_p = wr_p && !flag_p[address_p] && flag_m[address_p];
    inc        = {1'b0, comp_m} + {1'b0, comp_p};
    count_sum  = {1'b0, point_count} + {{ADDR_WIDTH{1'b0}}, inc};
    count_next = (count_sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : count_sum[ADDR_WIDTH:0];
  end

  always_ff @(posedge clk125 or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      num_lat     <= '0;
      point_count <= '0;
      flag_m      <= '0;
      flag_p      <= '0;
      dup_err     <= 1'b0;
      range_err   <= 1'b0;
    end else if (clear) begin
      state       <= S_IDLE;
      point_count <= '0;
      flag_m      <= '0;
      flag_p      <= '0;
      dup_err     <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            state       <= S_COLLECT;
            num_lat     <= num_points;
            point_count <= '0;
          end
        end
        S_COLLECT: begin
          if (point_count >= {1'b0, num_lat}) state <= S_DONE;
          point_count <= count_next;
          if (wr_m) flag_m[address_m] <= 1'b1;
          if (wr_p) flag_p[address_p] <= 1'b1;
          dup_err   <= dup_err | dup_m | dup_p;
          range_err <= range_err | rng_m | rng_p;
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk125) begin
    if (wr_m) ram_m[address_m] <= modulo;
    if (wr_p) ram_p[address_p] <= phase;
  end

  // Registered read sees the pre-write array contents, giving read-first behaviour.
  always_ff @(posedge clk125 or posedge areset) begin
    if (areset) begin
      sys_rdata  <= '0;
      sys_rflag  <= 1'b0;
      sys_rvalid <= 1'b0;
    end else begin
      sys_rvalid <= sys_rd;
      if (sys_rd) begin
        sys_rdata <= sys_addr[ADDR_WIDTH] ? ram_p[sys_addr[ADDR_WIDTH-1:0]]
                                          : ram_m[sys_addr[ADDR_WIDTH-1:0]];
        sys_rflag <= sys_addr[ADDR_WIDTH] ? flag_p[sys_addr[ADDR_WIDTH-1:0]]
                                          : flag_m[sys_addr[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign collecting = (state == S_COLLECT);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_sweep_result_collector.sv
// Directed bench for sweep_result_collector: capture, counting, errors, read port, clear and async reset.
module tb_sweep_result_collector;

  logic        clk125 = 1'b0;
  logic        areset = 1'b1;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  num_points = '0;
  logic        valid_m = 1'b0;
  logic [31:0] modulo = '0;
  logic [7:0]  address_m = '0;
  logic        valid_p = 1'b0;
  logic [31:0] phase = '0;
  logic [7:0]  address_p = '0;
  logic        sys_rd = 1'b0;
  logic [8:0]  sys_addr = '0;
  logic [31:0] sys_rdata;
  logic        sys_rvalid;
  logic        sys_rflag;
  logic [8:0]  point_count;
  logic        collecting;
  logic        done;
  logic        dup_err;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  sweep_result_collector #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk125(clk125), .areset(areset), .arm(arm), .clear(clear), .num_points(num_points),
    .valid_m(valid_m), .modulo(modulo), .address_m(address_m),
    .valid_p(valid_p), .phase(phase), .address_p(address_p),
    .sys_rd(sys_rd), .sys_addr(sys_addr), .sys_rdata(sys_rdata), .sys_rvalid(sys_rvalid),
    .sys_rflag(sys_rflag), .point_count(point_count), .collecting(collecting), .done(done),
    .dup_err(dup_err), .range_err(range_err)
  );

  always #4 clk125 = ~clk125;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic send(input logic vm, input logic [7:0] am, input logic [31:0] dm,
                      input logic vp, input logic [7:0] ap, input logic [31:0] dp);
    valid_m = vm; address_m = am; modulo = dm;
    valid_p = vp; address_p = ap; phase = dp;
    tick();
    valid_m = 1'b0; valid_p = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a);
    sys_rd = 1'b1; sys_addr = a;
    tick();
    sys_rd = 1'b0;
  endtask

  task automatic start(input logic [7:0] n);
    arm = 1'b1; num_points = n;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    // Reset state
    #10;
    check("rst_count", point_count, 0);
    check("rst_flags_out", {collecting, done, dup_err, range_err, sys_rvalid, sys_rflag}, 0);
    check("rst_rdata", sys_rdata, 0);
    tick();
    areset = 1'b0;
    tick();

    // 1: three points, M then P
    start(8'd3);
    check("t1_collecting", collecting, 1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'(i), 32'h10 + 32'(i), 1'b0, 8'd0, 32'd0);
      check("t1_count_after_m", point_count, 64'(i));
      send(1'b0, 8'd0, 32'd0, 1'b1, 8'(i), -32'sd1 * 32'(i));
      check("t1_count_after_p", point_count, 64'(i + 1));
    end
    check("t1_done_n1", done, 0);
    tick();
    check("t1_done_n2", done, 1);
    check("t1_not_collecting", collecting, 0);
    rd(9'h002);
    check("t1_rd_m2", sys_rdata, 32'h12);
    check("t1_rflag_m2", sys_rflag, 1);
    check("t1_rvalid", sys_rvalid, 1);
    tick();
    check("t1_rvalid_pulse", sys_rvalid, 0);
    rd(9'h102);
    check("t1_rd_p2", sys_rdata, 32'hFFFF_FFFE);
    tick();
    check("t1_rdata_hold", sys_rdata, 32'hFFFF_FFFE);
    send(1'b1, 8'd0, 32'h99, 1'b0, 8'd0, 32'd0);
    rd(9'h000);
    check("t5_done_ignored", sys_rdata, 32'h10);
    check("t5_done_nodup", dup_err, 0);

    // 5a: clear from DONE, IDLE ignores results
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_idle", {collecting, done}, 0);
    check("clr_count", point_count, 0);
    rd(9'h002);
    check("clr_flag", sys_rflag, 0);
    send(1'b1, 8'd0, 32'h77, 1'b0, 8'd0, 32'd0);
    rd(9'h000);
    check("t5_idle_ignored", sys_rdata, 32'h10);
    check("t5_idle_flag", sys_rflag, 0);

    // 2: simultaneous strobes
    start(8'd8);
    send(1'b1, 8'd4, 32'h14, 1'b1, 8'd4, 32'h44);
    check("t2_same_idx", point_count, 1);
    send(1'b1, 8'd5, 32'h15, 1'b0, 8'd0, 32'd0);
    send(1'b0, 8'd0, 32'd0, 1'b1, 8'd6, 32'h66);
    check("t2_partners_only", point_count, 1);
    send(1'b1, 8'd6, 32'h16, 1'b1, 8'd5, 32'h55);
    check("t2_two_idx", point_count, 3);

    // 3: duplicate and range errors
    send(1'b1, 8'd1, 32'h11, 1'b0, 8'd0, 32'd0);
    check("t3_nodup_yet", dup_err, 0);
    send(1'b1, 8'd1, 32'hAA, 1'b0, 8'd0, 32'd0);
    check("t3_dup_err", dup_err, 1);
    check("t3_dup_count", point_count, 3);
    rd(9'h001);
    check("t3_dup_data", sys_rdata, 32'hAA);
    send(1'b1, 8'd9, 32'h99, 1'b0, 8'd0, 32'd0);
    check("t3_range_err", range_err, 1);
    rd(9'h009);
    check("t3_range_noflag", sys_rflag, 0);

    // 4: read-first collision
    send(1'b1, 8'd3, 32'h33, 1'b0, 8'd0, 32'd0);
    sys_rd = 1'b1; sys_addr = 9'h003;
    valid_m = 1'b1; address_m = 8'd3; modulo = 32'h55;
    tick();
    sys_rd = 1'b0; valid_m = 1'b0;
    check("t4_old_data", sys_rdata, 32'h33);
    rd(9'h003);
    check("t4_new_data", sys_rdata, 32'h55);
    sys_rd = 1'b1; sys_addr = 9'h007;
    valid_m = 1'b1; address_m = 8'd7; modulo = 32'h77;
    tick();
    sys_rd = 1'b0; valid_m = 1'b0;
    check("t4_old_flag", sys_rflag, 0);
    rd(9'h007);
    check("t4_new_flag", sys_rflag, 1);
    check("t4_count", point_count, 3);

    // 5: clear mid-COLLECT with a strobe
    clear = 1'b1;
    valid_m = 1'b1; address_m = 8'd0; modulo = 32'hCC;
    tick();
    clear = 1'b0; valid_m = 1'b0;
    check("t5_clr_state", {collecting, done}, 0);
    check("t5_clr_count", point_count, 0);
    check("t5_clr_errs", {dup_err, range_err}, 0);
    rd(9'h000);
    check("t5_strobe_dropped", sys_rdata, 32'h10);
    check("t5_flag_cleared", sys_rflag, 0);

    // 6: asynchronous reset mid-sweep
    start(8'd2);
    send(1'b1, 8'd0, 32'h20, 1'b1, 8'd0, 32'h21);
    check("t6_pre_count", point_count, 1);
    #2 areset = 1'b1;
    #1;
    check("t6_async_count", point_count, 0);
    check("t6_async_state", {collecting, done, dup_err, range_err, sys_rvalid, sys_rflag}, 0);
    check("t6_async_rdata", sys_rdata, 0);
    #2 areset = 1'b0;
    tick();
    rd(9'h000);
    check("t6_flag_reset", sys_rflag, 0);
    start(8'd1);
    check("t6_rearm", collecting, 1);
    send(1'b1, 8'd0, 32'h30, 1'b1, 8'd0, 32'h31);
    check("t6_count", point_count, 1);
    tick();
    check("t6_done", done, 1);
    rd(9'h000);
    check("t6_data", sys_rdata, 32'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
